// File: rtl/cond_unit_mctx_if.sv
// Instruction/flag/stack bus between the pipeline and cond_unit_mctx.
// master = pipeline side, slave = conditional-execution unit.
interface cond_unit_mctx_if #(
    parameter int unsigned NCTX = 4
);
    localparam int unsigned CTXW = (NCTX > 1) ? $clog2(NCTX) : 1;

    logic            valid_i;
    logic [CTXW-1:0] ctx_i;
    logic [3:0]      cond_i;
    logic [3:0]      alu_flags_i;
    logic [1:0]      flag_w_i;
    logic            pcs_i;
    logic            reg_w_i;
    logic            mem_w_i;
    logic            exc_push_i;
    logic            exc_pop_i;
    logic            pcsrc_o;
    logic            regwrite_o;
    logic            memwrite_o;
    logic            condex_o;
    logic            valid_o;
    logic [3:0]      flags_o;
    logic            undef_o;
    logic            stack_err_o;

    modport master (
        output valid_i, ctx_i, cond_i, alu_flags_i, flag_w_i, pcs_i, reg_w_i, mem_w_i,
               exc_push_i, exc_pop_i,
        input  pcsrc_o, regwrite_o, memwrite_o, condex_o, valid_o, flags_o, undef_o,
               stack_err_o
    );

    modport slave (
        input  valid_i, ctx_i, cond_i, alu_flags_i, flag_w_i, pcs_i, reg_w_i, mem_w_i,
               exc_push_i, exc_pop_i,
        output pcsrc_o, regwrite_o, memwrite_o, condex_o, valid_o, flags_o, undef_o,
               stack_err_o
    );
endinterface

// File: rtl/cond_unit_mctx.sv
// Multi-context ARM condition unit: NZCV banks, cond evaluation, write-strobe gating, flag save stacks.
// Optional macro COND_NV_TRAP_EN: cond 4'hF raises a one-cycle registered undef_o pulse.
module cond_unit_mctx #(
    parameter int unsigned NCTX       = 4,
    parameter int unsigned SAVE_DEPTH = 2
) (
    input logic             clk,
    input logic             reset,
    cond_unit_mctx_if.slave bus
);
    localparam int unsigned PW = $clog2(SAVE_DEPTH + 1);
    localparam int unsigned SE = 2 ** PW;

    // Stack storage rounded up to the pointer range so every pointer value indexes legally.
    logic [3:0]    r_bank  [NCTX];
    logic [3:0]    r_stack [NCTX][SE];
    logic [PW-1:0] r_ptr   [NCTX];

    logic r_pcsrc, r_regwrite, r_memwrite, r_condex, r_valid, r_err;

    logic          w_ctx_ok;
    logic [3:0]    w_cur;
    logic [PW-1:0] w_ptr;
    logic [3:0]    w_top;
    logic          w_cond;
    logic          w_condex;
    logic          w_push_only, w_pop_only, w_full, w_empty;

    assign w_ctx_ok    = (32'(bus.ctx_i) < NCTX);
    assign w_cur       = w_ctx_ok ? r_bank[bus.ctx_i] : 4'b0000;
    assign w_ptr       = w_ctx_ok ? r_ptr[bus.ctx_i] : '0;
    assign w_top       = r_stack[bus.ctx_i][w_ptr - 1'b1];
    assign w_full      = (w_ptr == PW'(SAVE_DEPTH));
    assign w_empty     = (w_ptr == '0);
    assign w_push_only = bus.exc_push_i & ~bus.exc_pop_i & w_ctx_ok;
    assign w_pop_only  = bus.exc_pop_i & ~bus.exc_push_i & w_ctx_ok;

    always_comb begin
        w_cond = 1'b0;
        unique case (bus.cond_i)
            4'h0: w_cond = w_cur[2];
            4'h1: w_cond = ~w_cur[2];
            4'h2: w_cond = w_cur[1];
            4'h3: w_cond = ~w_cur[1];
            4'h4: w_cond = w_cur[3];
            4'h5: w_cond = ~w_cur[3];
            4'h6: w_cond = w_cur[0];
            4'h7: w_cond = ~w_cur[0];
            4'h8: w_cond = w_cur[1] & ~w_cur[2];
            4'h9: w_cond = ~(w_cur[1] & ~w_cur[2]);
            4'hA: w_cond = (w_cur[3] == w_cur[0]);
            4'hB: w_cond = (w_cur[3] != w_cur[0]);
            4'hC: w_cond = ~w_cur[2] & (w_cur[3] == w_cur[0]);
            4'hD: w_cond = ~(~w_cur[2] & (w_cur[3] == w_cur[0]));
            4'hE: w_cond = 1'b1;
            4'hF: w_cond = 1'b0;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_condex = bus.valid_i & w_ctx_ok & w_cond;

`ifdef COND_NV_TRAP_EN
    logic r_undef;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCTX; i++) begin
                r_bank[i] <= 4'b0000;
                r_ptr[i]  <= '0;
                for (int unsigned j = 0; j < SE; j++) r_stack[i][j] <= 4'b0000;
            end
            r_pcsrc    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            r_condex   <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
`ifdef COND_NV_TRAP_EN
            r_undef    <= 1'b0;
`endif
        end else begin
            r_valid    <= bus.valid_i;
            r_condex   <= w_condex;
            r_pcsrc    <= bus.pcs_i & w_condex;
            r_regwrite <= bus.reg_w_i & w_condex;
            r_memwrite <= bus.mem_w_i & w_condex;
`ifdef COND_NV_TRAP_EN
            r_undef    <= bus.valid_i & (bus.cond_i == 4'hF);
`endif
            if (w_ctx_ok) begin
                // A successful pop wins over the same-cycle instruction flag write.
                if (w_pop_only && !w_empty) begin
                    r_bank[bus.ctx_i]     <= w_top;
                    r_ptr[bus.ctx_i]      <= w_ptr - 1'b1;
                end else if (w_condex) begin
                    if (bus.flag_w_i[1]) r_bank[bus.ctx_i][3:2] <= bus.alu_flags_i[3:2];
                    if (bus.flag_w_i[0]) r_bank[bus.ctx_i][1:0] <= bus.alu_flags_i[1:0];
                end
                if (w_push_only && !w_full) begin
                    r_stack[bus.ctx_i][w_ptr] <= w_cur;
                    r_ptr[bus.ctx_i]          <= w_ptr + 1'b1;
                end
                if ((bus.exc_push_i && bus.exc_pop_i) || (w_push_only && w_full) ||
                    (w_pop_only && w_empty)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.pcsrc_o     = r_pcsrc;
    assign bus.regwrite_o  = r_regwrite;
    assign bus.memwrite_o  = r_memwrite;
    assign bus.condex_o    = r_condex;
    assign bus.valid_o     = r_valid;
    assign bus.flags_o     = w_cur;
    assign bus.stack_err_o = r_err;
`ifdef COND_NV_TRAP_EN
    assign bus.undef_o     = r_undef;
`else
    assign bus.undef_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cond_unit_mctx.sv
// Bench for cond_unit_mctx: directed scenarios then random traffic against a flag/stack model.
module tb_cond_unit_mctx;
    localparam int NCTX = 4;
    localparam int SD   = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    cond_unit_mctx_if #(.NCTX(NCTX)) bus ();

    cond_unit_mctx #(.NCTX(NCTX), .SAVE_DEPTH(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] m_bank [NCTX];
    logic [3:0] m_stk  [NCTX][$];
    bit         m_err;

    // Predicates pair up: even code tests the base condition, odd code its inverse.
    function automatic bit model_cond(logic [3:0] c, logic [3:0] f);
        bit n = f[3], z = f[2], cf = f[1], v = f[0];
        bit base = 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCTX; i++) begin
            m_bank[i] = 4'b0000;
            m_stk[i].delete();
        end
        m_err = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [1:0] c, input logic [3:0] cd,
                         input logic [3:0] alu, input logic [1:0] fw, input bit pcs,
                         input bit rw, input bit mw, input bit psh, input bit pp);
        bus.valid_i     = v;
        bus.ctx_i       = c;
        bus.cond_i      = cd;
        bus.alu_flags_i = alu;
        bus.flag_w_i    = fw;
        bus.pcs_i       = pcs;
        bus.reg_w_i     = rw;
        bus.mem_w_i     = mw;
        bus.exc_push_i  = psh;
        bus.exc_pop_i   = pp;
    endtask

    task automatic step(input bit v, input logic [1:0] c, input logic [3:0] cd,
                        input logic [3:0] alu, input logic [1:0] fw, input bit pcs,
                        input bit rw, input bit mw, input bit psh, input bit pp);
        bit         ex;
        bit         und;
        logic [3:0] nb;
        drive(v, c, cd, alu, fw, pcs, rw, mw, psh, pp);
        #1;
        chk("flags", bus.flags_o, m_bank[c]);
        ex = v && model_cond(cd, m_bank[c]);
`ifdef COND_NV_TRAP_EN
        und = v && (cd == 4'hF);
`else
        und = 1'b0;
`endif
        nb = m_bank[c];
        if (ex && fw[1]) nb[3:2] = alu[3:2];
        if (ex && fw[0]) nb[1:0] = alu[1:0];
        if (psh && pp) m_err = 1'b1;
        if (psh && !pp) begin
            if (m_stk[c].size() >= SD) m_err = 1'b1;
            else m_stk[c].push_back(m_bank[c]);
        end
        if (pp && !psh) begin
            if (m_stk[c].size() == 0) m_err = 1'b1;
            else nb = m_stk[c].pop_back();
        end
        m_bank[c] = nb;
        @(posedge clk);
        #1;
        chk("valid_o", bus.valid_o, v);
        chk("condex_o", bus.condex_o, ex);
        chk("pcsrc_o", bus.pcsrc_o, pcs && ex);
        chk("regwrite_o", bus.regwrite_o, rw && ex);
        chk("memwrite_o", bus.memwrite_o, mw && ex);
        chk("undef_o", bus.undef_o, und);
        chk("stack_err_o", bus.stack_err_o, m_err);
    endtask

    task automatic show(input logic [1:0] c, input logic [3:0] exp);
        drive(1'b0, c, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flags_const", bus.flags_o, exp);
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        #2;
        chk("rst_condex", bus.condex_o, 1'b0);
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_pcsrc", bus.pcsrc_o, 1'b0);
        chk("rst_err", bus.stack_err_o, 1'b0);
        chk("rst_flags", bus.flags_o, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Compare then EQ / NE on ctx0
        step(1, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        show(0, 4'b0100);
        step(1, 0, 4'h0, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        step(1, 0, 4'h1, 4'b0000, 2'b00, 0, 1, 0, 0, 0);

        // Independent banks, GE on mismatched N/V
        step(1, 1, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0, 0);
        step(1, 2, 4'hE, 4'b0001, 2'b11, 0, 0, 0, 0, 0);
        step(1, 1, 4'hA, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        step(1, 2, 4'hA, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        show(0, 4'b0100);

        // Failed EQ suppresses every strobe and the flag write
        step(1, 0, 4'hE, 4'b0010, 2'b11, 0, 0, 0, 0, 0);
        step(1, 0, 4'h0, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
        show(0, 4'b0010);

        // Save, overwrite, restore, then underflow
        step(1, 0, 4'hE, 4'b0110, 2'b11, 0, 0, 0, 0, 0);
        step(0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 1, 0);
        step(1, 0, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
        step(0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        show(0, 4'b0110);
        step(0, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        show(0, 4'b0110);
        chk("underflow_err", bus.stack_err_o, 1'b1);

        // Overflow on ctx3 with SAVE_DEPTH=2
        do_reset();
        step(1, 3, 4'hE, 4'b0011, 2'b11, 0, 0, 0, 0, 0);
        step(0, 3, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 1, 0);
        step(1, 3, 4'hE, 4'b0101, 2'b11, 0, 0, 0, 0, 0);
        step(0, 3, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 1, 0);
        chk("no_err_yet", bus.stack_err_o, 1'b0);
        step(1, 3, 4'hE, 4'b1100, 2'b11, 0, 0, 0, 0, 0);
        step(0, 3, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 1, 0);
        chk("overflow_err", bus.stack_err_o, 1'b1);
        step(0, 3, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        show(3, 4'b0101);
        step(0, 3, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 1);
        show(3, 4'b0011);

        // Never condition
        step(1, 0, 4'hF, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
        step(1, 0, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 0);

        // Random traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(3) != 0), 2'($urandom_range(NCTX - 1)), 4'($urandom),
                 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(5) == 0), ($urandom_range(5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
